// File: rtl/bcd_down_counter_pkg.sv
// -----------------------------------------------------------------------------
// bcd_down_counter_pkg
// Shared constants and helpers for the BCD down counter and its digit cells.
//   BCD_W    : width of one BCD digit
//   BCD_MAX  : largest legal digit value (9)
//   BCD_ZERO : digit value zero
//   bcd_sat  : clamp a 4-bit value into the legal BCD range
// -----------------------------------------------------------------------------
package bcd_down_counter_pkg;

  localparam int              BCD_W    = 4;
  localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

  // Codes 10..15 are not BCD; they are treated as "as large as possible".
  function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_counter_digit.sv
// -----------------------------------------------------------------------------
// mod10_down_digit
// One decade cell of the BCD down counter.
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset, digit -> 0
//   load       : load load_digit (saturated to 9); takes priority over dec_in
//   load_digit : BCD value to load
//   dec_in     : decrement this digit on the next edge (0 -> 9)
//   digit      : registered digit value, always 0..9
//   is_zero    : digit == 0
// -----------------------------------------------------------------------------
module mod10_down_digit
  import bcd_down_counter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  input  logic             dec_in,
  output logic [BCD_W-1:0] digit,
  output logic             is_zero
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_sat(load_digit);
    end else if (dec_in) begin
      digit_d = (digit_q == BCD_ZERO) ? BCD_MAX : (digit_q - 4'd1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit   = digit_q;
  assign is_zero = (digit_q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// -----------------------------------------------------------------------------
// bcd_down_counter
// Cascadable DIGITS-digit BCD down counter used as a countdown/timeout timer.
// Parameters:
//   DIGITS : number of BCD digits (count is 4*DIGITS bits, digit 0 in [3:0])
//   WRAP   : 1 -> all-zero decrements to all-nines with a borrow pulse
//            0 -> all-zero holds
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset (count=0, zero=1, borrow_out=0)
//   en         : decrement request
//   load       : synchronous load of load_val, wins over en
//   load_val   : BCD start value, digits above 9 saturate to 9
//   count      : registered BCD count
//   zero       : registered, high when count is all-zero
//   borrow_out : registered one-cycle pulse on wrap-around underflow
// -----------------------------------------------------------------------------
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int WRAP   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    zero,
  output logic                    borrow_out
);

  localparam int CW      = BCD_W * DIGITS;
  localparam bit WRAP_EN = (WRAP != 0);

  logic [DIGITS-1:0] is_zero;
  logic [DIGITS-1:0] dec_in;
  // lower_zero[k]: digits 0..k-1 are all zero (lower_zero[0] is the empty set).
  logic [DIGITS:0]   lower_zero;
  logic              all_zero;
  logic              dec_ok;
  logic              count_is_one;

  logic zero_q, zero_d;
  logic borrow_q, borrow_d;

  assign lower_zero[0] = 1'b1;
  assign all_zero      = lower_zero[DIGITS];

  // Without wrap, an all-zero count must not ripple into nines.
  assign dec_ok = en & ~load & (WRAP_EN | ~all_zero);

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign lower_zero[k+1] = lower_zero[k] & is_zero[k];
    assign dec_in[k]       = dec_ok & lower_zero[k];

    mod10_down_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_digit (load_val[k*BCD_W +: BCD_W]),
      .dec_in     (dec_in[k]),
      .digit      (count[k*BCD_W +: BCD_W]),
      .is_zero    (is_zero[k])
    );
  end

  assign count_is_one = (count == CW'(1));

  // zero is predicted from the current count so it lands in the same cycle
  // as the count it describes. Saturation only maps 10..15 to 9, so a
  // saturated load value is zero exactly when the raw value is zero.
  always_comb begin
    zero_d   = zero_q;
    borrow_d = 1'b0;
    if (load) begin
      zero_d = (load_val == '0);
    end else if (en) begin
      if (all_zero) begin
        zero_d   = ~WRAP_EN;
        borrow_d = WRAP_EN;
      end else begin
        zero_d = count_is_one;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zero_q   <= 1'b1;
      borrow_q <= 1'b0;
    end else begin
      zero_q   <= zero_d;
      borrow_q <= borrow_d;
    end
  end

  assign zero       = zero_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_down_counter
// Three counters share one stimulus stream: DIGITS=2/WRAP=1, DIGITS=2/WRAP=0
// and DIGITS=1/WRAP=1. An integer reference model predicts every cycle; the
// expected values are queued when inputs are driven and popped by a monitor
// after the following clock edge.
// -----------------------------------------------------------------------------
module tb_bcd_down_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0] cnt_a, cnt_b;
  logic [3:0] cnt_c;
  logic       zero_a, zero_b, zero_c;
  logic       brw_a, brw_b, brw_c;

  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(2), .WRAP(1)) u_d2w1 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .count(cnt_a), .zero(zero_a), .borrow_out(brw_a));

  bcd_down_counter #(.DIGITS(2), .WRAP(0)) u_d2w0 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .count(cnt_b), .zero(zero_b), .borrow_out(brw_b));

  bcd_down_counter #(.DIGITS(1), .WRAP(1)) u_d1w1 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val[3:0]),
    .count(cnt_c), .zero(zero_c), .borrow_out(brw_c));

  typedef struct packed {
    logic [2:0][7:0] cnt;
    logic [2:0]      zero;
    logic [2:0]      brw;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: plain integer value per instance.
  int DG[3] = '{2, 2, 1};
  int WR[3] = '{1, 0, 1};
  int m_val[3];
  bit m_brw[3];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int bcd_value(input logic [7:0] v, input int d);
    int s = 0;
    int w = 1;
    for (int k = 0; k < d; k++) begin
      int dg = int'(v[4*k +: 4]);
      if (dg > 9) dg = 9;
      s += dg * w;
      w *= 10;
    end
    return s;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'((v / 10) % 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_val[i] = 0;
      m_brw[i] = 1'b0;
    end
  endtask

  task automatic step(input bit e, input bit l, input logic [7:0] lv);
    exp_t x;
    @(negedge clk);
    en = e;
    load = l;
    load_val = lv;
    for (int i = 0; i < 3; i++) begin
      int top = (DG[i] == 1) ? 9 : 99;
      m_brw[i] = 1'b0;
      if (l) begin
        m_val[i] = bcd_value(lv, DG[i]);
      end else if (e) begin
        if (m_val[i] == 0) begin
          if (WR[i] != 0) begin
            m_val[i] = top;
            m_brw[i] = 1'b1;
          end
        end else begin
          m_val[i] = m_val[i] - 1;
        end
      end
      x.cnt[i]  = to_bcd(m_val[i]);
      x.zero[i] = (m_val[i] == 0);
      x.brw[i]  = m_brw[i];
    end
    exp_q.push_back(x);
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cnt_d2w1",  cnt_a,         e.cnt[0]);
        chk("zero_d2w1", {7'd0, zero_a}, {7'd0, e.zero[0]});
        chk("brw_d2w1",  {7'd0, brw_a},  {7'd0, e.brw[0]});
        chk("cnt_d2w0",  cnt_b,         e.cnt[1]);
        chk("zero_d2w0", {7'd0, zero_b}, {7'd0, e.zero[1]});
        chk("brw_d2w0",  {7'd0, brw_b},  {7'd0, e.brw[1]});
        chk("cnt_d1w1",  {4'd0, cnt_c},  e.cnt[2]);
        chk("zero_d1w1", {7'd0, zero_c}, {7'd0, e.zero[2]});
        chk("brw_d1w1",  {7'd0, brw_c},  {7'd0, e.brw[2]});
      end
    end
  end

  // Borrow pulse recorder for the single-digit free-running window
  bit win = 1'b0;
  int cyc = 0;
  int pulse_cyc[$];
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (win && brw_c) pulse_cyc.push_back(cyc);
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cnt_a"},  cnt_a,          8'h00);
    chk({tag, "_zero_a"}, {7'd0, zero_a}, 8'h01);
    chk({tag, "_brw_a"},  {7'd0, brw_a},  8'h00);
    chk({tag, "_cnt_b"},  cnt_b,          8'h00);
    chk({tag, "_zero_b"}, {7'd0, zero_b}, 8'h01);
    chk({tag, "_cnt_c"},  {4'd0, cnt_c},  8'h00);
    chk({tag, "_zero_c"}, {7'd0, zero_c}, 8'h01);
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b0;
    #1 chk_reset_state("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Countdown with tens borrow at 40 -> 39
    step(1'b0, 1'b1, 8'h42);
    repeat (5) step(1'b1, 1'b0, 8'h00);

    // Underflow: wrap (with borrow) versus hold
    step(1'b0, 1'b1, 8'h01);
    repeat (3) step(1'b1, 1'b0, 8'h00);

    // Load wins over en, illegal digit saturates
    step(1'b1, 1'b1, 8'hA5);
    step(1'b0, 1'b0, 8'h00);

    // Asynchronous reset mid-count, no clock edge in between
    step(1'b0, 1'b1, 8'h37);
    step(1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 chk_reset_state("async");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    // First enabled edge after release underflows from zero
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);

    // Single digit, en held 30 cycles from zero
    step(1'b0, 1'b1, 8'h00);
    win = 1'b1;
    repeat (30) step(1'b1, 1'b0, 8'h00);
    @(posedge clk);
    #2 win = 1'b0;
    chk("d1_pulses", 8'(pulse_cyc.size()), 8'd3);
    if (pulse_cyc.size() == 3) begin
      chk("d1_gap1", 8'(pulse_cyc[1] - pulse_cyc[0]), 8'd10);
      chk("d1_gap2", 8'(pulse_cyc[2] - pulse_cyc[1]), 8'd10);
    end

    // Randomized traffic, loads biased toward small values to reach underflow
    for (int n = 0; n < 400; n++) begin
      bit         l, e;
      logic [7:0] lv;
      l  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 3) != 0);
      lv = 8'($urandom);
      if ($urandom_range(0, 1) == 0) lv = {4'd0, 4'($urandom_range(0, 3))};
      step(e, l, lv);
    end
    step(1'b0, 1'b0, 8'h00);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
